// File: rtl/cond_wb_unit.sv
// Conditional-execution and writeback unit sitting right after the ALU.
// It holds the NZCV flags, evaluates the ARM condition field against them,
// gates the PC, register and memory writes, and spreads a 64-bit
// long-multiply result over two register-file write cycles.
// Ports:
//   clk, reset             clock; synchronous active-low reset
//   Cond                   condition field of the current instruction
//   ALUFlags, FlagW        new {N,Z,C,V} and the per-half update enables
//   PCS, RegW, MemW        raw write requests from the decoder
//   NoWrite, LongMul       compare-type and 64-bit-result qualifiers
//   Result, ResultExtra    low and high ALU results
//   RdLo, RdHi             destinations of the low and high results
//   CondEx, PCSrc          condition passed; gated PC write
//   RegWrite, MemWrite     gated register-file and memory write enables
//   WA3, WD3               register-file write address and data
//   Stall                  hold the upstream instruction this cycle
//   Flags                  stored {N,Z,C,V}
module cond_wb_unit #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             LongMul,
  input  logic [WIDTH-1:0] Result,
  input  logic [WIDTH-1:0] ResultExtra,
  input  logic [RA_W-1:0]  RdLo,
  input  logic [RA_W-1:0]  RdHi,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [RA_W-1:0]  WA3,
  output logic [WIDTH-1:0] WD3,
  output logic             Stall,
  output logic [3:0]       Flags
);

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic [WIDTH-1:0] hi_data_q;
  logic [RA_W-1:0]  hi_addr_q;
  logic             hi_load;

  logic n_f;
  logic z_f;
  logic c_f;
  logic v_f;

  assign n_f   = flags_q[3];
  assign z_f   = flags_q[2];
  assign c_f   = flags_q[1];
  assign v_f   = flags_q[0];
  assign Flags = flags_q;

  // Condition check only ever sees the stored flags, so the flags an
  // instruction produces take effect from the next instruction on.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    hi_load  = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    Stall    = 1'b0;
    WA3      = '0;
    WD3      = '0;

    unique case (state_q)
      IDLE: begin
        PCSrc    = PCS & CondEx;
        MemWrite = MemW & CondEx;
        RegWrite = RegW & CondEx & ~NoWrite;
        WA3      = RdLo;
        WD3      = Result;
        if (CondEx & FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
        if (CondEx & FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        // Low half goes out now; the high half is parked for one cycle
        // while upstream is held on the same instruction.
        if (LongMul & RegWrite) begin
          Stall   = 1'b1;
          hi_load = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        // The replayed upstream instruction is ignored here.
        RegWrite = 1'b1;
        WA3      = hi_addr_q;
        WD3      = hi_data_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!reset) begin
      PCSrc    = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Stall    = 1'b0;
      WA3      = '0;
      WD3      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      flags_q   <= 4'b0000;
      hi_data_q <= '0;
      hi_addr_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (hi_load) begin
        hi_data_q <= ResultExtra;
        hi_addr_q <= RdHi;
      end
    end
  end

endmodule

// File: tb/tb_cond_wb_unit.sv
// Bench for cond_wb_unit: directed steps plus random traffic, all
// compared every cycle against a transaction-level reference model.
module tb_cond_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cond;
  logic [3:0]  alu_flags;
  logic [1:0]  flag_w;
  logic        pcs;
  logic        reg_w;
  logic        mem_w;
  logic        no_write;
  logic        long_mul;
  logic [31:0] result;
  logic [31:0] result_extra;
  logic [3:0]  rd_lo;
  logic [3:0]  rd_hi;
  logic        cond_ex;
  logic        pc_src;
  logic        reg_write;
  logic        mem_write;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        stall;
  logic [3:0]  flags;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [3:0]  m_flags;
  bit          m_pend;
  logic [3:0]  m_hi_addr;
  logic [31:0] m_hi_data;

  always #5 clk = ~clk;

  cond_wb_unit #(.WIDTH(32), .RA_W(4)) dut (
    .clk(clk), .reset(rst_n), .Cond(cond), .ALUFlags(alu_flags),
    .FlagW(flag_w), .PCS(pcs), .RegW(reg_w), .MemW(mem_w),
    .NoWrite(no_write), .LongMul(long_mul), .Result(result),
    .ResultExtra(result_extra), .RdLo(rd_lo), .RdHi(rd_hi),
    .CondEx(cond_ex), .PCSrc(pc_src), .RegWrite(reg_write),
    .MemWrite(mem_write), .WA3(wa3), .WD3(wd3), .Stall(stall),
    .Flags(flags)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Pairs of predicates; odd codes are the complement of the even one.
  function automatic bit passes(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return c[0] == 1'b0;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Compare this cycle's outputs to the model, then clock and advance it.
  task automatic cycle();
    bit          ce, e_pc, e_rw, e_mw, e_st;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    logic [3:0]  nf;
    @(negedge clk);
    ce = passes(cond, m_flags);
    e_pc = 0; e_rw = 0; e_mw = 0; e_st = 0; e_wa = 0; e_wd = 0;
    nf = m_flags;
    if (rst_n && m_pend) begin
      e_rw = 1; e_wa = m_hi_addr; e_wd = m_hi_data;
    end else if (rst_n) begin
      e_pc = pcs && ce;
      e_mw = mem_w && ce;
      e_rw = reg_w && ce && !no_write;
      e_wa = rd_lo;
      e_wd = result;
      e_st = long_mul && e_rw;
      if (ce && flag_w[1]) nf[3:2] = alu_flags[3:2];
      if (ce && flag_w[0]) nf[1:0] = alu_flags[1:0];
    end
    check("cond_ex", 32'(cond_ex), 32'(ce));
    check("pc_src", 32'(pc_src), 32'(e_pc));
    check("reg_write", 32'(reg_write), 32'(e_rw));
    check("mem_write", 32'(mem_write), 32'(e_mw));
    check("wa3", 32'(wa3), 32'(e_wa));
    check("wd3", wd3, e_wd);
    check("stall", 32'(stall), 32'(e_st));
    check("flags", 32'(flags), 32'(m_flags));
    @(posedge clk);
    if (!rst_n) begin
      m_flags = 4'b0000;
      m_pend  = 0;
    end else if (m_pend) begin
      m_pend = 0;
    end else begin
      m_flags = nf;
      if (e_st) begin
        m_pend    = 1;
        m_hi_addr = rd_hi;
        m_hi_data = result_extra;
      end
    end
    #1;
  endtask

  task automatic idle_in();
    cond = 4'b1110; alu_flags = 0; flag_w = 0; pcs = 0; reg_w = 0;
    mem_w = 0; no_write = 0; long_mul = 0; result = 0;
    result_extra = 0; rd_lo = 0; rd_hi = 0;
  endtask

  task automatic rand_in();
    cond         = 4'($urandom);
    alu_flags    = 4'($urandom);
    flag_w       = 2'($urandom);
    pcs          = 1'($urandom);
    reg_w        = 1'($urandom);
    mem_w        = 1'($urandom);
    no_write     = ($urandom_range(0, 3) == 0);
    long_mul     = 1'($urandom);
    result       = $urandom;
    result_extra = $urandom;
    rd_lo        = 4'($urandom);
    rd_hi        = 4'($urandom);
  endtask

  task automatic long_mul_in();
    idle_in();
    result = 32'hFFFF_FBF5; result_extra = 32'hFFFF_FFFF;
    rd_lo = 4'd2; rd_hi = 4'd3; long_mul = 1; reg_w = 1;
  endtask

  initial begin
    m_pend = 0; m_flags = 0; m_hi_addr = 0; m_hi_data = 0;
    // 1: reset held two cycles, then release
    idle_in(); reg_w = 1; rd_lo = 4'd5; result = 32'h1234;
    rst_n = 0;
    @(posedge clk); #1;
    #2;
    check("t1_rst_rw", 32'(reg_write), 32'd0);
    check("t1_rst_stall", 32'(stall), 32'd0);
    check("t1_rst_flags", 32'(flags), 32'd0);
    cycle();
    rst_n = 1; #2;
    check("t1_rw", 32'(reg_write), 32'd1);
    check("t1_wa3", 32'(wa3), 32'd5);
    cycle();

    // 2: set Z, then evaluate EQ/NE/LS
    idle_in(); flag_w = 2'b11; alu_flags = 4'b0100; cycle();
    idle_in(); #2;
    check("t2_flags", 32'(flags), 32'h4);
    cond = 4'b0000; #1; check("t2_eq", 32'(cond_ex), 32'd1); cycle();
    cond = 4'b0001; #1; check("t2_ne", 32'(cond_ex), 32'd0); cycle();
    cond = 4'b1001; #1; check("t2_ls", 32'(cond_ex), 32'd1); cycle();

    // 3: update only C,V
    idle_in(); flag_w = 2'b01; alu_flags = 4'b1011; cycle();
    idle_in(); #2;
    check("t3_flags", 32'(flags), 32'h7);
    cond = 4'b1010; #1; check("t3_ge", 32'(cond_ex), 32'd0); cycle();
    cond = 4'b1101; #1; check("t3_le", 32'(cond_ex), 32'd1); cycle();

    // 4: long multiply -45*23
    long_mul_in(); #2;
    check("t4_c0_wa3", 32'(wa3), 32'd2);
    check("t4_c0_wd3", wd3, 32'hFFFF_FBF5);
    check("t4_c0_stall", 32'(stall), 32'd1);
    cycle();
    rand_in(); #2;
    check("t4_c1_wa3", 32'(wa3), 32'd3);
    check("t4_c1_wd3", wd3, 32'hFFFF_FFFF);
    check("t4_c1_rw", 32'(reg_write), 32'd1);
    check("t4_c1_stall", 32'(stall), 32'd0);
    cycle();
    idle_in(); reg_w = 1; rd_lo = 4'd9; #2;
    check("t4_c2_wa3", 32'(wa3), 32'd9);
    check("t4_c2_stall", 32'(stall), 32'd0);
    cycle();

    // 5: failing NE blocks every write and flag update
    idle_in(); flag_w = 2'b11; alu_flags = 4'b0100; cycle();
    idle_in(); cond = 4'b0001; pcs = 1; mem_w = 1; reg_w = 1;
    flag_w = 2'b11; alu_flags = 4'b1111; #2;
    check("t5_pc", 32'(pc_src), 32'd0);
    check("t5_mw", 32'(mem_write), 32'd0);
    check("t5_rw", 32'(reg_write), 32'd0);
    cycle();
    check("t5_flags", 32'(flags), 32'h4);

    // reserved condition and RdLo==RdHi long multiply
    idle_in(); cond = 4'b1111; reg_w = 1; flag_w = 2'b11;
    alu_flags = 4'b1010; cycle();
    check("rsv_flags", 32'(flags), 32'h4);
    long_mul_in(); rd_hi = 4'd2; cycle();
    idle_in(); cycle();

    // 6: reset during the hi cycle
    long_mul_in(); cycle();
    rand_in(); rst_n = 0; #2;
    check("t6_rw", 32'(reg_write), 32'd0);
    cycle();
    check("t6_flags", 32'(flags), 32'd0);
    rst_n = 1; idle_in(); reg_w = 1; long_mul = 0; #2;
    check("t6_stall", 32'(stall), 32'd0);
    cycle();

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rand_in();
      rst_n = ($urandom_range(0, 29) != 0);
      cycle();
    end
    rst_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
